// File: rtl/chaos_pkg.sv
// Shared constants and state encoding for the logistic-map iterator.
// Fixed-point format is unsigned Q4.28 throughout.
package chaos_pkg;

  localparam int          FRAC_BITS = 28;
  localparam logic [31:0] Q_ONE     = 32'h1000_0000;
  localparam logic [31:0] R_MAX     = 32'h4000_0000;

  typedef enum logic [1:0] {
    IDLE,
    MUL_A,
    MUL_B,
    DONE
  } state_e;

endpackage

// File: rtl/chaos_fx_mul.sv
// Combinational unsigned Q4.28 multiply: full 64-bit product, truncated
// back to Q4.28 by dropping the low FRAC_BITS bits.
module chaos_fx_mul #(
  parameter int FRAC_BITS = 28
) (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] p_o
);

  logic [63:0] prod;

  assign prod = {32'd0, a_i} * {32'd0, b_i};
  assign p_o  = 32'(prod >> FRAC_BITS);

endmodule

// File: rtl/chaos_logistic_iter.sv
// Logistic-map iterator x(n+1) = r*x*(1-x) fed by PIO output words; one
// shared multiplier computes x*(1-x) in MUL_A and r*p in MUL_B.
module chaos_logistic_iter #(
  parameter int FRAC_BITS = chaos_pkg::FRAC_BITS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] r_in,
  input  logic [31:0] x0_in,
  input  logic [31:0] cfg_in,
  output logic [31:0] x_out,
  output logic        x_valid,
  output logic        busy,
  output logic        done,
  output logic        sat
);

  import chaos_pkg::*;

  state_e      state_q, state_d;
  logic        run_d_q;
  logic        armed_q;
  logic [31:0] r_q, r_d;
  logic [31:0] x_q, x_d;
  logic [31:0] p_q, p_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] x_out_q, x_out_d;
  logic        x_valid_q, x_valid_d;
  logic        done_q, done_d;
  logic        sat_q, sat_d;

  logic        run;
  logic [15:0] n_iter;
  logic        start;
  logic        r_over, x_over;
  logic [31:0] mul_a, mul_b, mul_p;
  logic        unused_cfg;

  assign run        = cfg_in[0];
  assign n_iter     = cfg_in[31:16];
  assign unused_cfg = ^cfg_in[15:1];
  assign r_over     = (r_in > R_MAX);
  assign x_over     = (x0_in > Q_ONE);

  // armed_q blocks a start while run is still held high coming out of reset.
  assign start = (state_q == IDLE) && run && !run_d_q && armed_q;

  assign mul_a = (state_q == MUL_B) ? r_q : x_q;
  assign mul_b = (state_q == MUL_B) ? p_q : (Q_ONE - x_q);

  chaos_fx_mul #(
    .FRAC_BITS (FRAC_BITS)
  ) u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      run_d_q   <= 1'b0;
      armed_q   <= 1'b0;
      r_q       <= '0;
      x_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      x_out_q   <= '0;
      x_valid_q <= 1'b0;
      done_q    <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_d_q   <= run;
      armed_q   <= armed_q | !run;
      r_q       <= r_d;
      x_q       <= x_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      x_out_q   <= x_out_d;
      x_valid_q <= x_valid_d;
      done_q    <= done_d;
      sat_q     <= sat_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (start) state_d = (n_iter == 16'd0) ? DONE : MUL_A;
      MUL_A: state_d = run ? MUL_B : IDLE;
      MUL_B: begin
        if (!run)              state_d = IDLE;
        else if (cnt_q > 16'd1) state_d = MUL_A;
        else                   state_d = DONE;
      end
      DONE:  if (!run) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    r_d       = r_q;
    x_d       = x_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    x_out_d   = x_out_q;
    x_valid_d = 1'b0;
    done_d    = done_q;
    sat_d     = sat_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          r_d   = r_over ? R_MAX : r_in;
          x_d   = x_over ? Q_ONE : x0_in;
          cnt_d = n_iter;
          sat_d = r_over || x_over;
        end
      end
      MUL_A: if (run) p_d = mul_p;
      MUL_B: begin
        if (run) begin
          x_d       = mul_p;
          x_out_d   = mul_p;
          x_valid_d = 1'b1;
          cnt_d     = cnt_q - 16'd1;
          if (cnt_q == 16'd1) done_d = 1'b1;
        end
      end
      DONE: begin
        // A zero-length run arrives here with done still low: publish the seed once.
        if (!run) begin
          done_d = 1'b0;
        end else if (!done_q) begin
          x_out_d   = x_q;
          x_valid_d = 1'b1;
          done_d    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign x_out   = x_out_q;
  assign x_valid = x_valid_q;
  assign busy    = (state_q == MUL_A) || (state_q == MUL_B);
  assign done    = done_q;
  assign sat     = sat_q;

endmodule

// File: tb/tb_chaos_logistic_iter.sv
// Directed bench for chaos_logistic_iter: hand-computed Q4.28 iterates,
// cycle-exact x_valid/busy/done timing, clamping, abort and reset recovery.
module tb_chaos_logistic_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] r_in, x0_in, cfg_in;
  logic [31:0] x_out;
  logic        x_valid, busy, done, sat;

  int n_cmp = 0;
  int n_bad = 0;

  chaos_logistic_iter dut (
    .clk     (clk),
    .reset   (reset),
    .r_in    (r_in),
    .x0_in   (x0_in),
    .cfg_in  (cfg_in),
    .x_out   (x_out),
    .x_valid (x_valid),
    .busy    (busy),
    .done    (done),
    .sat     (sat)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic run, input logic [15:0] n);
    cfg_in = {n, 15'd0, run};
  endtask

  // Drives the operands with run high and returns just after start edge E0.
  task automatic start_run(input logic [31:0] r, input logic [31:0] x, input logic [15:0] n);
    r_in  = r;
    x0_in = x;
    set_cfg(1'b1, n);
    tick();
  endtask

  task automatic stop_run;
    set_cfg(1'b0, 16'd0);
    tick();
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL stop_done: got %b expected 0", done);
    end
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    r_in  = '0;
    x0_in = '0;
    set_cfg(1'b0, 16'd0);
    #2;
    n_cmp++;
    if ({x_out, x_valid, busy, done, sat} !== 36'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got x_out=%h v=%b b=%b d=%b s=%b expected all 0",
               x_out, x_valid, busy, done, sat);
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_basic;
    start_run(32'h2000_0000, 32'h0800_0000, 16'd1);
    n_cmp++;
    if (busy !== 1'b1 || x_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_e0: got busy=%b v=%b expected busy=1 v=0", busy, x_valid);
    end
    tick();
    n_cmp++;
    if (x_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_e1_valid: got %b expected 0", x_valid);
    end
    tick();
    n_cmp++;
    if (x_valid !== 1'b1 || x_out !== 32'h0800_0000) begin
      n_bad++;
      $display("FAIL basic_e2_iter: got v=%b x=%h expected v=1 x=08000000", x_valid, x_out);
    end
    n_cmp++;
    if (done !== 1'b1 || sat !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_e2_status: got d=%b s=%b b=%b expected d=1 s=0 b=0", done, sat, busy);
    end
    tick();
    n_cmp++;
    if (x_valid !== 1'b0 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL basic_hold: got v=%b d=%b expected v=0 d=1", x_valid, done);
    end
    stop_run();
  endtask

  task automatic test_r3;
    start_run(32'h3000_0000, 32'h0400_0000, 16'd1);
    tick();
    tick();
    n_cmp++;
    if (x_valid !== 1'b1 || x_out !== 32'h0900_0000) begin
      n_bad++;
      $display("FAIL r3_iter: got v=%b x=%h expected v=1 x=09000000", x_valid, x_out);
    end
    stop_run();
  endtask

  task automatic test_back_to_back;
    logic [4:0]  exp_busy  = 5'b01111;
    logic [4:0]  exp_valid = 5'b10100;
    logic [4:0]  exp_done  = 5'b10000;
    logic [31:0] exp_x;
    start_run(32'h4000_0000, 32'h0800_0000, 16'd2);
    r_in  = 32'h1234_5678;
    x0_in = 32'h0321_0000;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      n_cmp++;
      if (busy !== exp_busy[k] || x_valid !== exp_valid[k] || done !== exp_done[k]) begin
        n_bad++;
        $display("FAIL b2b_ctrl_k%0d: got b=%b v=%b d=%b expected b=%b v=%b d=%b",
                 k, busy, x_valid, done, exp_busy[k], exp_valid[k], exp_done[k]);
      end
      if (exp_valid[k]) begin
        exp_x = (k == 2) ? 32'h1000_0000 : 32'h0000_0000;
        n_cmp++;
        if (x_out !== exp_x) begin
          n_bad++;
          $display("FAIL b2b_iter_k%0d: got %h expected %h", k, x_out, exp_x);
        end
      end
    end
    stop_run();
  endtask

  task automatic test_sat;
    start_run(32'h5000_0000, 32'h2000_0000, 16'd1);
    tick();
    tick();
    n_cmp++;
    if (x_valid !== 1'b1 || x_out !== 32'h0000_0000 || sat !== 1'b1 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL sat_iter: got v=%b x=%h s=%b d=%b expected v=1 x=00000000 s=1 d=1",
               x_valid, x_out, sat, done);
    end
    stop_run();
  endtask

  task automatic test_zero_n;
    start_run(32'h3000_0000, 32'h0ABC_0000, 16'd0);
    n_cmp++;
    if (busy !== 1'b0 || x_valid !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_e0: got b=%b v=%b d=%b expected all 0", busy, x_valid, done);
    end
    tick();
    n_cmp++;
    if (x_valid !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || x_out !== 32'h0ABC_0000) begin
      n_bad++;
      $display("FAIL zero_e1: got v=%b d=%b b=%b x=%h expected v=1 d=1 b=0 x=0abc0000",
               x_valid, done, busy, x_out);
    end
    n_cmp++;
    if (sat !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_sat: got %b expected 0", sat);
    end
    tick();
    n_cmp++;
    if (x_valid !== 1'b0 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_e2: got v=%b d=%b expected v=0 d=1", x_valid, done);
    end
    stop_run();
  endtask

  task automatic test_abort;
    logic stray = 1'b0;
    start_run(32'h3000_0000, 32'h0400_0000, 16'd5);
    tick();
    tick();
    n_cmp++;
    if (x_valid !== 1'b1 || x_out !== 32'h0900_0000) begin
      n_bad++;
      $display("FAIL abort_iter1: got v=%b x=%h expected v=1 x=09000000", x_valid, x_out);
    end
    tick();
    tick();
    n_cmp++;
    if (x_valid !== 1'b1 || x_out !== 32'h0BD0_0000) begin
      n_bad++;
      $display("FAIL abort_iter2: got v=%b x=%h expected v=1 x=0bd00000", x_valid, x_out);
    end
    set_cfg(1'b0, 16'd5);
    tick();
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || x_valid !== 1'b0 || x_out !== 32'h0BD0_0000) begin
      n_bad++;
      $display("FAIL abort_idle: got b=%b d=%b v=%b x=%h expected b=0 d=0 v=0 x=0bd00000",
               busy, done, x_valid, x_out);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      if (x_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) stray = 1'b1;
    end
    n_cmp++;
    if (stray !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_quiet: got activity=%b expected 0", stray);
    end
    start_run(32'h2000_0000, 32'h0800_0000, 16'd1);
    tick();
    tick();
    n_cmp++;
    if (x_valid !== 1'b1 || x_out !== 32'h0800_0000 || done !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_restart: got v=%b x=%h d=%b expected v=1 x=08000000 d=1",
               x_valid, x_out, done);
    end
    stop_run();
  endtask

  task automatic test_reset_mid;
    logic stray = 1'b0;
    start_run(32'h4800_0000, 32'h0400_0000, 16'd3);
    tick();
    tick();
    n_cmp++;
    if (x_out !== 32'h0C00_0000 || sat !== 1'b1) begin
      n_bad++;
      $display("FAIL rstmid_iter1: got x=%h s=%b expected x=0c000000 s=1", x_out, sat);
    end
    tick();
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({x_out, x_valid, busy, done, sat} !== 36'd0) begin
      n_bad++;
      $display("FAIL rstmid_outputs: got x=%h v=%b b=%b d=%b s=%b expected all 0",
               x_out, x_valid, busy, done, sat);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy !== 1'b0 || x_valid !== 1'b0 || done !== 1'b0) stray = 1'b1;
    end
    n_cmp++;
    if (stray !== 1'b0) begin
      n_bad++;
      $display("FAIL rstmid_no_restart: got activity=%b expected 0", stray);
    end
    set_cfg(1'b0, 16'd1);
    tick();
    start_run(32'h2000_0000, 32'h0800_0000, 16'd1);
    tick();
    tick();
    n_cmp++;
    if (x_valid !== 1'b1 || x_out !== 32'h0800_0000) begin
      n_bad++;
      $display("FAIL rstmid_restart: got v=%b x=%h expected v=1 x=08000000", x_valid, x_out);
    end
    stop_run();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_r3();
    test_back_to_back();
    test_sat();
    test_zero_n();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
